// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
//   Shares one SPI master core among NUM_REQ requesters. Round-robin grant,
//   one chip select per requester, per-transfer configuration latched at
//   grant time, and sequencing of the core start/busy/new_data handshake.
//   Received data is returned with a one-cycle done pulse to the winner.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to enable a watchdog over the
//   START/XFER phases. On expiry the core is reset for one cycle, err is set
//   and the transfer is closed normally through HOLD and DONE.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   req_i               level request per requester, held until its done
//   req_cfg_i           per requester {div[5:0], bits[4:0], cpha, cpol}
//   req_wdata_i         per requester transmit word
//   gnt_o               one-hot grant, SETUP through HOLD
//   done_o              one-cycle completion pulse to the winner
//   rdata_o, err_o      received word / watchdog abort flag, valid with done
//   spi_cs_n_o          chip selects, active low
//   spi_start_o         start strobe to the core
//   spi_rst_o           core reset, active high
//   spi_cpol_o, spi_cpha_o, spi_bits_o, spi_div_o, spi_wdata_o
//                       latched configuration and transmit word to the core
//   spi_rdata_i, spi_busy_i, spi_new_data_i
//                       core receive word and status
// ---------------------------------------------------------------------------
// state  | meaning
// IDLE   | no transfer; wait for any request
// ARB    | pick round-robin winner, latch cfg/wdata, assert gnt and cs_n
// SETUP  | cs_n low for CS_SETUP cycles before start
// START  | spi_start high until the core reports busy
// XFER   | wait for end of transfer (busy low with new_data), capture rdata
// HOLD   | cs_n held low for CS_HOLD cycles, then released with gnt
// DONE   | one-cycle done pulse to the winner
// ---------------------------------------------------------------------------
module spi_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_DATA_WIDTH = 32,
    parameter int CS_SETUP       = 2,
    parameter int CS_HOLD        = 2,
    parameter int TIMEOUT        = 1023
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ*13-1:0]             req_cfg_i,
    input  logic [NUM_REQ*MAX_DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    output logic [NUM_REQ-1:0]                done_o,
    output logic [MAX_DATA_WIDTH-1:0]         rdata_o,
    output logic                              err_o,
    output logic [NUM_REQ-1:0]                spi_cs_n_o,
    output logic                              spi_start_o,
    output logic                              spi_rst_o,
    output logic                              spi_cpol_o,
    output logic                              spi_cpha_o,
    output logic [4:0]                        spi_bits_o,
    output logic [5:0]                        spi_div_o,
    output logic [MAX_DATA_WIDTH-1:0]         spi_wdata_o,
    input  logic [MAX_DATA_WIDTH-1:0]         spi_rdata_i,
    input  logic                              spi_busy_i,
    input  logic                              spi_new_data_i
);

    localparam int IW      = $clog2(NUM_REQ);
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_SETUP = 3'd2,
        ST_START = 3'd3,
        ST_XFER  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             rr_q, rr_d;
    logic [IW-1:0]             win_q, win_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [NUM_REQ-1:0]        cs_n_q, cs_n_d;
    logic [12:0]               cfg_q, cfg_d;
    logic [MAX_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MAX_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      spi_rst_q;

    logic                      arb_found;
    logic [IW-1:0]             arb_idx;
    logic [IW-1:0]             scan_idx;
    logic [NUM_REQ-1:0]        arb_oh;
    logic                      wd_hit;
    logic                      abort;

    logic [12:0]               cfg_arr   [NUM_REQ];
    logic [MAX_DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign cfg_arr[g]   = req_cfg_i[13*g +: 13];
        assign wdata_arr[g] = req_wdata_i[MAX_DATA_WIDTH*g +: MAX_DATA_WIDTH];
    end

    // Scan requesters starting at the round-robin pointer; first hit wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = IW'((int'(rr_q) + i) % NUM_REQ);
            if (!arb_found && req_i[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
    end

    assign arb_oh = NUM_REQ'(1) << arb_idx;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    logic [WD_W-1:0] wd_q, wd_d;

    // Down-counter loaded on entry to START; terminal count while in
    // START/XFER means the core never completed.
    assign wd_hit = ((state_q == ST_START) || (state_q == ST_XFER)) && (wd_q == '0);

    always_comb begin
        wd_d = wd_q;
        if ((state_q == ST_SETUP) && (cnt_q == '0)) begin
            wd_d = WD_W'(TIMEOUT - 1);
        end else if (((state_q == ST_START) || (state_q == ST_XFER)) && (wd_q != '0)) begin
            wd_d = wd_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign wd_hit         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        cs_n_d  = cs_n_q;
        cfg_d   = cfg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        abort   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (arb_found) begin
                    win_d   = arb_idx;
                    rr_d    = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    gnt_d   = arb_oh;
                    cs_n_d  = ~arb_oh;
                    cfg_d   = cfg_arr[arb_idx];
                    wdata_d = wdata_arr[arb_idx];
                    err_d   = 1'b0;
                    cnt_d   = CW'(CS_SETUP - 1);
                    state_d = ST_SETUP;
                end else begin
                    // request withdrawn between IDLE and ARB
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_START: begin
                if (wd_hit) begin
                    abort = 1'b1;
                end else if (spi_busy_i) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // A completion in the same cycle as watchdog expiry wins.
                if (!spi_busy_i && spi_new_data_i) begin
                    rdata_d = spi_rdata_i;
                    cnt_d   = CW'(CS_HOLD - 1);
                    state_d = ST_HOLD;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    gnt_d   = '0;
                    cs_n_d  = '1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            err_d   = 1'b1;
            cnt_d   = CW'(CS_HOLD - 1);
            state_d = ST_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rr_q      <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            cs_n_q    <= '1;
            cfg_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            spi_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            cs_n_q    <= cs_n_d;
            cfg_q     <= cfg_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            spi_rst_q <= 1'b0;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = (state_q == ST_DONE) ? (NUM_REQ'(1) << win_q) : '0;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign spi_cs_n_o  = cs_n_q;
    assign spi_start_o = (state_q == ST_START);
    assign spi_rst_o   = spi_rst_q | abort;
    assign spi_cpol_o  = cfg_q[0];
    assign spi_cpha_o  = cfg_q[1];
    assign spi_bits_o  = cfg_q[6:2];
    assign spi_div_o   = cfg_q[12:7];
    assign spi_wdata_o = wdata_q;

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

    localparam int N        = 4;
    localparam int W        = 32;
    localparam int SETUP    = 2;
    localparam int HOLD     = 2;
    localparam int TMO      = 15;
    localparam int BUSY_LEN = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [N*13-1:0] req_cfg;
    logic [N*W-1:0] req_wdata;
    logic [N-1:0]   gnt, done, spi_cs_n;
    logic [W-1:0]   rdata, spi_wdata, spi_rdata;
    logic           err, spi_start, spi_rst, spi_cpol, spi_cpha;
    logic [4:0]     spi_bits;
    logic [5:0]     spi_div;
    logic           spi_busy, spi_new_data;

    always #5 clk = ~clk;

    spi_arbiter #(
        .NUM_REQ(N), .MAX_DATA_WIDTH(W), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req), .req_cfg_i(req_cfg), .req_wdata_i(req_wdata),
        .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .err_o(err),
        .spi_cs_n_o(spi_cs_n), .spi_start_o(spi_start), .spi_rst_o(spi_rst),
        .spi_cpol_o(spi_cpol), .spi_cpha_o(spi_cpha), .spi_bits_o(spi_bits),
        .spi_div_o(spi_div), .spi_wdata_o(spi_wdata),
        .spi_rdata_i(spi_rdata), .spi_busy_i(spi_busy), .spi_new_data_i(spi_new_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int rr);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (rr + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic cond(input int sel, input int idx);
        case (sel)
            0: return done[idx];
            1: return |done;
            2: return spi_busy;
            3: return |gnt;
            4: return spi_start;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int idx, input int limit, input string name);
        int   n;
        logic hit;
        n   = 0;
        hit = cond(sel, idx);
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            hit = cond(sel, idx);
        end
        check(name, {63'b0, hit}, 64'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- core model: echoes the transmit word ----------------
    logic         core_silent = 1'b0;
    int           core_cnt    = 0;
    logic [W-1:0] core_word;

    initial begin
        spi_busy     = 1'b0;
        spi_new_data = 1'b0;
        spi_rdata    = '0;
        core_word    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                spi_busy     = 1'b0;
                spi_new_data = 1'b0;
                core_cnt     = 0;
            end else begin
                spi_new_data = 1'b0;
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        spi_busy     = 1'b0;
                        spi_new_data = 1'b1;
                        spi_rdata    = core_word;
                    end
                end else if (spi_start && !spi_busy && !core_silent) begin
                    spi_busy  = 1'b1;
                    core_word = spi_wdata;
                    core_cnt  = BUSY_LEN;
                end
            end
        end
    end

    // ---------------- behavioural model and per-cycle compare ----------------
    logic [N-1:0]    prev_req = '0, prev_gnt = '0, prev_done = '0;
    logic [N*W-1:0]  prev_wd = '0;
    logic [N*13-1:0] prev_cfg = '0;
    int              m_rr = 0, m_win = 0, m_since = 0, c_w;
    logic            m_active = 1'b0, m_started = 1'b0, exp_err = 1'b0;
    logic [W-1:0]    m_wdata = '0, m_last = '0;
    logic [12:0]     m_cfg = '0, act_cfg;
    logic [N-1:0]    exp_g, exp_cs;
    int              grant_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_rr      = 0;
                m_active  = 1'b0;
                m_last    = '0;
                prev_gnt  = '0;
                prev_done = '0;
            end else begin
                check("gnt_at_most_one", {63'b0, ($countones(gnt) <= 1)}, 64'd1);
                exp_cs = ~gnt;
                check("cs_n_vs_gnt", spi_cs_n, exp_cs);
                if (gnt != '0 && prev_gnt == '0) begin
                    c_w   = pick(prev_req, m_rr);
                    exp_g = (c_w >= 0) ? (N'(1) << c_w) : '0;
                    check("grant_winner", gnt, exp_g);
                    if (c_w >= 0) begin
                        m_win     = c_w;
                        m_rr      = (c_w + 1) % N;
                        m_wdata   = prev_wd[c_w*W +: W];
                        m_cfg     = prev_cfg[c_w*13 +: 13];
                        m_since   = 0;
                        m_active  = 1'b1;
                        m_started = 1'b0;
                        grant_log.push_back(c_w);
                    end
                end else if (m_active) begin
                    m_since++;
                end
                if (m_active && gnt != '0) begin
                    exp_g   = N'(1) << m_win;
                    act_cfg = {spi_div, spi_bits, spi_cpha, spi_cpol};
                    check("gnt_held", gnt, exp_g);
                    check("spi_wdata_latched", spi_wdata, m_wdata);
                    check("spi_cfg_latched", act_cfg, m_cfg);
                end
                if (m_active && spi_start && !m_started) begin
                    m_started = 1'b1;
                    check("cs_setup_before_start", m_since, SETUP);
                end
                if (done != '0) begin
                    exp_g = N'(1) << m_win;
                    check("done_has_grant", {63'b0, m_active}, 64'd1);
                    check("done_winner", done, exp_g);
                    check("done_one_cycle", prev_done, 0);
                    check("done_cs_released", spi_cs_n, {N{1'b1}});
                    check("done_err", err, exp_err);
                    if (exp_err) begin
                        check("rdata_kept_on_abort", rdata, m_last);
                    end else begin
                        check("rdata_echo", rdata, m_wdata);
                        m_last = m_wdata;
                    end
                    m_active = 1'b0;
                end
                prev_gnt  = gnt;
                prev_done = done;
            end
            prev_req = req;
            prev_wd  = req_wdata;
            prev_cfg = req_cfg;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    // ---------------- directed stimulus ----------------
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int g0, n;

    initial begin
        req       = '0;
        req_cfg   = '0;
        req_wdata = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_cs_n", spi_cs_n, 4'hF);
        check("rst_start", spi_start, 0);
        check("rst_spi_rst", spi_rst, 1);
        check("rst_spi_wdata", spi_wdata, 0);
        check("rst_spi_cfg", {spi_div, spi_bits, spi_cpha, spi_cpol}, 0);
        step();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("spi_rst_released", spi_rst, 0);

        // single request: cpol=0 cpha=0 bits=7 div=4, echo 0xA5
        req_cfg[0*13 +: 13]  = {6'd4, 5'd7, 1'b0, 1'b0};
        req_wdata[0*W +: W]  = 32'h0000_00A5;
        req_cfg[1*13 +: 13]  = {6'd2, 5'd15, 1'b0, 1'b1};
        req_wdata[1*W +: W]  = 32'h1111_0001;
        req_cfg[2*13 +: 13]  = {6'd9, 5'd15, 1'b1, 1'b1};
        req_wdata[2*W +: W]  = 32'h1234_5678;
        req_cfg[3*13 +: 13]  = {6'd63, 5'd31, 1'b1, 1'b0};
        req_wdata[3*W +: W]  = 32'hCAFE_0003;
        step();
        req = 4'b0001;
        n = 0;
        while (!spi_start && n < 50) begin
            @(negedge clk);
            if (!spi_start) n++;
        end
        check("req_to_start_latency", n, 2 + SETUP);
        check("cs0_low_at_start", spi_cs_n, 4'b1110);
        check("start_cfg", {spi_div, spi_bits, spi_cpha, spi_cpol}, {6'd4, 5'd7, 1'b0, 1'b0});
        wait_for(0, 0, 100, "wait_done0");
        check("t1_rdata", rdata, 32'hA5);
        check("t1_err", err, 0);
        check("t1_done", done, 4'b0001);
        step();
        req = '0;
        step();
        check("t1_done_cleared", done, 0);

        // reset during XFER
        req_wdata[0*W +: W] = 32'h0000_5A5A;
        step();
        req = 4'b0001;
        wait_for(2, 0, 100, "wait_busy_rst");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", spi_cs_n, 4'hF);
        check("midrst_gnt", gnt, 0);
        check("midrst_spi_rst", spi_rst, 1);
        check("midrst_start", spi_start, 0);
        req = 4'b1001;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_for(3, 0, 100, "wait_gnt_after_rst");
        check("rr_restart_at_0", gnt, 4'b0001);
        wait_for(0, 0, 100, "wait_done0_after_rst");
        check("after_rst_rdata", rdata, 32'h5A5A);
        step();
        req = 4'b1000;
        wait_for(0, 3, 100, "wait_done3");
        check("req3_rdata", rdata, 32'hCAFE_0003);
        step();
        req = '0;
        repeat (3) step();

        // all requesting, rr=0: order 0,1,2,3,0
        g0 = grant_log.size();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_for(1, 0, 100, "wait_done_rr");
            step();
        end
        req = '0;
        repeat (3) step();
        check("rr_grant_count", grant_log.size() - g0, 5);
        for (int t = 0; t < 5; t++) begin
            if (g0 + t < grant_log.size()) check("rr_order", grant_log[g0+t], exp_order[t]);
        end

        // req[2] arrives during req[1] transfer; then cfg/wdata change mid-XFER
        req = 4'b0010;
        wait_for(2, 0, 100, "wait_busy_req1");
        step();
        req = 4'b0110;
        check("req1_gnt_kept", gnt, 4'b0010);
        wait_for(0, 1, 100, "wait_done1");
        check("req1_rdata", rdata, 32'h1111_0001);
        step();
        req = 4'b0100;
        wait_for(3, 0, 100, "wait_gnt2");
        check("gnt_req2", gnt, 4'b0100);
        wait_for(2, 0, 100, "wait_busy_req2");
        step();
        req_cfg[2*13 +: 13] = {6'd1, 5'd3, 1'b0, 1'b0};
        req_wdata[2*W +: W] = 32'hDEAD_BEEF;
        step();
        check("midxfer_wdata", spi_wdata, 32'h1234_5678);
        check("midxfer_cfg", {spi_div, spi_bits, spi_cpha, spi_cpol}, {6'd9, 5'd15, 1'b1, 1'b1});
        wait_for(0, 2, 100, "wait_done2");
        check("req2_rdata", rdata, 32'h1234_5678);
        step();
        req = '0;
        repeat (3) step();

`ifdef SPI_ARB_TIMEOUT_EN
        // core never responds: watchdog aborts on cycle TMO of START
        core_silent = 1'b1;
        exp_err     = 1'b1;
        req = 4'b1000;
        wait_for(4, 0, 100, "wait_start_tmo");
        n = 1;
        while (!spi_rst && n < 4 * TMO) begin
            @(negedge clk);
            n++;
        end
        check("tmo_spi_rst_cycle", n, TMO);
        @(negedge clk);
        check("tmo_spi_rst_pulse", spi_rst, 0);
        wait_for(0, 3, 100, "wait_done_tmo");
        check("tmo_err", err, 1);
        check("tmo_rdata_kept", rdata, 32'h1234_5678);
        step();
        req = '0;
        repeat (2) step();
        exp_err     = 1'b0;
        core_silent = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
